// File: rtl/alu_operand_loader_if.sv
// Pin-side bus of the ALU operand loader: byte bus, strobe and control in,
// registered operands, held result and status out.
interface alu_operand_loader_if #(
    parameter int DATA_W = 8
);
    logic              ena;
    logic [DATA_W-1:0] data_in;
    logic              load_strobe;
    logic              clear;
    logic [DATA_W-1:0] result_in;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [1:0]        op_out;
    logic [DATA_W-1:0] result_out;
    logic              result_valid;
    logic              busy;
    logic [2:0]        phase;
    logic [7:0]        op_count;

    modport master (
        output ena, data_in, load_strobe, clear, result_in,
        input  a_out, b_out, op_out, result_out, result_valid, busy, phase, op_count
    );

    modport slave (
        input  ena, data_in, load_strobe, clear, result_in,
        output a_out, b_out, op_out, result_out, result_valid, busy, phase, op_count
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Sequential ALU front end: loads A, B and opcode from one byte bus on
// synchronized strobe edges, then captures and holds the ALU result.
module alu_operand_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    hist_q, hist_d;
    logic                    strobe_evt_s;
    logic [DATA_W-1:0]       a_q, a_d;
    logic [DATA_W-1:0]       b_q, b_d;
    logic [1:0]              op_q, op_d;
    logic [DATA_W-1:0]       result_q, result_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic [7:0]              count_q, count_d;

    // Synchronizer and edge history run regardless of ena or clear.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], bus.load_strobe};
        hist_d       = sync_q[SYNC_STAGES-1];
        strobe_evt_s = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Sequencer next state: clear beats the enable hold, which beats strobe events.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (bus.clear) begin
            state_d  = S_A;
            a_d      = {DATA_W{1'b0}};
            b_d      = {DATA_W{1'b0}};
            op_d     = 2'd0;
            result_d = {DATA_W{1'b0}};
            valid_d  = 1'b0;
        end else if (!bus.ena) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_A, S_DONE: begin
                    if (strobe_evt_s) begin
                        a_d     = bus.data_in;
                        state_d = S_B;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_B: begin
                    if (strobe_evt_s) begin
                        b_d     = bus.data_in;
                        state_d = S_OP;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_OP: begin
                    if (strobe_evt_s) begin
                        op_d    = bus.data_in[1:0];
                        valid_d = 1'b0;
                        state_d = S_EXEC;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_EXEC: begin
                    // The ALU has had a full cycle on stable operands by now.
                    result_d = bus.result_in;
                    valid_d  = 1'b1;
                    count_d  = count_q + 8'd1;
                    state_d  = S_DONE;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
        busy_d = (state_d == S_B) || (state_d == S_OP) || (state_d == S_EXEC);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_A;
            sync_q   <= {SYNC_STAGES{1'b0}};
            hist_q   <= 1'b0;
            a_q      <= {DATA_W{1'b0}};
            b_q      <= {DATA_W{1'b0}};
            op_q     <= 2'd0;
            result_q <= {DATA_W{1'b0}};
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    assign bus.a_out        = a_q;
    assign bus.b_out        = b_q;
    assign bus.op_out       = op_q;
    assign bus.result_out   = result_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.phase        = state_q;
    assign bus.op_count     = count_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: vector table for complete operations
// plus hand-written sequences for gating, clear, wrap and async reset.
module tb_alu_operand_loader;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [7:0] exp_cnt;

    alu_operand_loader_if #(.DATA_W(8)) bus ();

    alu_operand_loader #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [1:0] exp_op;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_phase"}, 32'(bus.phase), 32'd0);
        check({tag, "_a"}, 32'(bus.a_out), 32'd0);
        check({tag, "_b"}, 32'(bus.b_out), 32'd0);
        check({tag, "_op"}, 32'(bus.op_out), 32'd0);
        check({tag, "_res"}, 32'(bus.result_out), 32'd0);
        check({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_cnt"}, 32'(bus.op_count), 32'd0);
    endtask

    // One-cycle strobe pulse; capture lands on the third edge after raising it.
    task automatic strobe_byte(input logic [7:0] d, input bit chk);
        logic [2:0] ph0;
        ph0 = bus.phase;
        bus.data_in     = d;
        bus.load_strobe = 1'b1;
        tick();
        bus.load_strobe = 1'b0;
        tick();
        if (chk) check("latency_early", 32'(bus.phase), 32'(ph0));
        tick();
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [7:0] res);
        bus.result_in = res;
        strobe_byte(a, 1'b0);
        strobe_byte(b, 1'b0);
        strobe_byte(opb, 1'b0);
        tick();
        exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = 8'd0;
        vecs[0] = '{a: 8'h3C, b: 8'h0F, opb: 8'h02, exp_op: 2'd2, res: 8'h5A};
        vecs[1] = '{a: 8'hFF, b: 8'h01, opb: 8'hFC, exp_op: 2'd0, res: 8'h00};
        vecs[2] = '{a: 8'h00, b: 8'hFF, opb: 8'hFD, exp_op: 2'd1, res: 8'h01};
        vecs[3] = '{a: 8'hA5, b: 8'h5A, opb: 8'hFF, exp_op: 2'd3, res: 8'hFF};
        vecs[4] = '{a: 8'h81, b: 8'h7E, opb: 8'h01, exp_op: 2'd1, res: 8'h03};

        bus.ena = 1'b1;
        bus.data_in = 8'h00;
        bus.load_strobe = 1'b0;
        bus.clear = 1'b0;
        bus.result_in = 8'h00;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_zero("reset");
        repeat (20) tick();
        check_zero("idle");

        // Normal sequence with latency checks on every capture.
        bus.result_in = 8'h5A;
        strobe_byte(8'h3C, 1'b1);
        check("norm_a", 32'(bus.a_out), 32'h3C);
        check("norm_phase_b", 32'(bus.phase), 32'd1);
        check("norm_busy", 32'(bus.busy), 32'd1);
        strobe_byte(8'h0F, 1'b1);
        check("norm_b", 32'(bus.b_out), 32'h0F);
        strobe_byte(8'h02, 1'b1);
        check("norm_op", 32'(bus.op_out), 32'd2);
        check("norm_phase_exec", 32'(bus.phase), 32'd3);
        tick();
        tick();
        exp_cnt = 8'd1;
        check("norm_res", 32'(bus.result_out), 32'h5A);
        check("norm_valid", 32'(bus.result_valid), 32'd1);
        check("norm_cnt", 32'(bus.op_count), 32'd1);
        check("norm_phase_done", 32'(bus.phase), 32'd4);
        check("norm_busy_done", 32'(bus.busy), 32'd0);

        // Back-to-back: old result stays readable until the new opcode capture.
        bus.result_in = 8'hC3;
        strobe_byte(8'h11, 1'b0);
        check("b2b_valid_a", 32'(bus.result_valid), 32'd1);
        check("b2b_res_a", 32'(bus.result_out), 32'h5A);
        strobe_byte(8'h22, 1'b0);
        check("b2b_valid_b", 32'(bus.result_valid), 32'd1);
        check("b2b_res_b", 32'(bus.result_out), 32'h5A);
        strobe_byte(8'h03, 1'b0);
        check("b2b_valid_op", 32'(bus.result_valid), 32'd0);
        bus.ena = 1'b0;
        repeat (3) tick();
        check("exec_hold_phase", 32'(bus.phase), 32'd3);
        check("exec_hold_cnt", 32'(bus.op_count), 32'(exp_cnt));
        bus.ena = 1'b1;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("b2b_res_new", 32'(bus.result_out), 32'hC3);
        check("b2b_valid_new", 32'(bus.result_valid), 32'd1);
        check("b2b_cnt", 32'(bus.op_count), 32'(exp_cnt));

        // clear mid-sequence from S_DONE -> S_B -> S_OP.
        strobe_byte(8'hAA, 1'b0);
        strobe_byte(8'h55, 1'b0);
        check("clr_pre_a", 32'(bus.a_out), 32'hAA);
        check("clr_pre_b", 32'(bus.b_out), 32'h55);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clr_phase", 32'(bus.phase), 32'd0);
        check("clr_a", 32'(bus.a_out), 32'd0);
        check("clr_b", 32'(bus.b_out), 32'd0);
        check("clr_valid", 32'(bus.result_valid), 32'd0);
        check("clr_cnt", 32'(bus.op_count), 32'(exp_cnt));

        // Held strobe: one capture only, even though data changes while held.
        bus.data_in = 8'h11;
        bus.load_strobe = 1'b1;
        repeat (3) tick();
        bus.data_in = 8'h22;
        repeat (7) tick();
        bus.load_strobe = 1'b0;
        repeat (3) tick();
        check("held_phase", 32'(bus.phase), 32'd1);
        check("held_a", 32'(bus.a_out), 32'h11);
        check("held_b", 32'(bus.b_out), 32'd0);

        // Strobe during ena=0 is discarded, not deferred.
        bus.ena = 1'b0;
        strobe_byte(8'h77, 1'b0);
        repeat (3) tick();
        bus.ena = 1'b1;
        repeat (5) tick();
        check("ena_phase", 32'(bus.phase), 32'd1);
        check("ena_b", 32'(bus.b_out), 32'd0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;

        // Vector table of complete operations.
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].res);
            check($sformatf("vec%0d_a", i), 32'(bus.a_out), 32'(vecs[i].a));
            check($sformatf("vec%0d_b", i), 32'(bus.b_out), 32'(vecs[i].b));
            check($sformatf("vec%0d_op", i), 32'(bus.op_out), 32'(vecs[i].exp_op));
            check($sformatf("vec%0d_res", i), 32'(bus.result_out), 32'(vecs[i].res));
            check($sformatf("vec%0d_valid", i), 32'(bus.result_valid), 32'd1);
            check($sformatf("vec%0d_cnt", i), 32'(bus.op_count), 32'(exp_cnt));
            check($sformatf("vec%0d_phase", i), 32'(bus.phase), 32'd4);
        end

        // 256 further operations: counter wraps back to the same value.
        for (int i = 0; i < 256; i++) begin
            do_op(8'(i), 8'(255 - i), 8'(i), 8'(i ^ 8'h3C));
            if (exp_cnt == 8'd0) check("wrap_zero", 32'(bus.op_count), 32'd0);
        end
        check("wrap_cnt", 32'(bus.op_count), 32'(exp_cnt));
        check("wrap_res", 32'(bus.result_out), 32'(8'hFF ^ 8'h3C));

        // Async reset while frozen in S_EXEC.
        bus.result_in = 8'h99;
        strobe_byte(8'h12, 1'b0);
        strobe_byte(8'h34, 1'b0);
        strobe_byte(8'h01, 1'b0);
        bus.ena = 1'b0;
        repeat (3) tick();
        check("rst_pre_phase", 32'(bus.phase), 32'd3);
        check("rst_pre_cnt", 32'(bus.op_count), 32'(exp_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        tick();
        check_zero("rst_held");
        rst_n = 1'b1;
        bus.ena = 1'b1;
        repeat (3) tick();
        check_zero("rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Sequential front end for the 8-bit ALU (two 8-bit operands, 2-bit opcode S, combinational 8-bit result). The ALU tile has only 8 input pins, so this block takes operand A, operand B and the opcode as three successive bytes on one 8-bit bus, each qualified by a strobe. It presents stable registered operands to the ALU, captures the ALU result into a holding register, and reports status. It sits between the tile pins and the ALU inside the top-level wrapper.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the load_strobe synchronizer (legal range 2..3)
DATA_W, 8, operand/result width (only 8 is verified)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; 0 freezes state and drops strobe events
data_in  input  8  byte bus from ui_in
load_strobe  input  1  asynchronous pin strobe (from uio_in[0])
clear  input  1  synchronous abort/clear (from uio_in[1])
result_in  input  8  combinational ALU result
a_out  output  8  registered operand A to ALU
b_out  output  8  registered operand B to ALU
op_out  output  2  registered opcode S to ALU
result_out  output  8  held result
result_valid  output  1  result_out holds a completed result
busy  output  1  sequence in progress (state not S_A and not S_DONE)
phase  output  3  state encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4
op_count  output  8  completed-operation counter

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assert, active-low. Under reset all flops are 0, state = S_A, and every output is 0.
- Synchronizer: load_strobe passes through a SYNC_STAGES-flop chain into a history flop. strobe_evt = sync_out & ~hist, one cycle per rising edge; a held-high strobe yields one event.
- Latency with SYNC_STAGES=2: strobe first sampled high at edge k, strobe_evt high in cycle k+2, capture at edge k+2.
- The synchronizer and history flop always run, including while ena=0. A strobe_evt that occurs while ena=0 is discarded; it is not deferred.
- Priority at each edge: reset > clear > ena=0 (hold) > strobe_evt.
- S_A: strobe_evt -> a_out<=data_in, go to S_B.
- S_B: strobe_evt -> b_out<=data_in, go to S_OP.
- S_OP: strobe_evt -> op_out<=data_in[1:0] (data_in[7:2] ignored), result_valid<=0, go to S_EXEC.
- S_EXEC: lasts one cycle, no strobe needed. result_out<=result_in, result_valid<=1, op_count<=op_count+1 (wraps 255->0), go to S_DONE. A strobe_evt in S_EXEC is dropped.
- S_DONE: result_out, result_valid and the operands hold. strobe_evt -> a_out<=data_in, go to S_B.
  - result_valid stays 1 until the next S_OP capture, so the previous result is readable while the next A and B are entered.
- clear: state<=S_A; a_out, b_out, op_out, result_out <= 0; result_valid<=0. op_count is kept.
  - clear in any state, mid-sequence included, aborts with no ALU capture.
- ena=0: all state and outputs hold, including in S_EXEC; the capture happens on the first edge with ena=1.
- Operands change only on their own capture edge. Between captures the ALU inputs are glitch-free register outputs.
- Reset asserted mid-sequence: immediate return to reset values, no partial result.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, released -> phase=0, all outputs 0; 20 idle cycles cause no change.
- Normal sequence: strobes with data_in=8'h3C, 8'h0F, 8'h02, bench holds result_in=8'h5A -> a_out=3C, b_out=0F, op_out=2.
  - Two cycles after the third capture: result_out=5A, result_valid=1, op_count=1, phase=4.
  - Each capture lands exactly SYNC_STAGES cycles after the strobe is first sampled high.
- Held strobe and ena gating: strobe held high for 10 cycles -> exactly one capture. A strobe pulse during ena=0 -> no capture, and no capture after ena returns to 1.
- clear mid-sequence: after A=8'hAA and B=8'h55, pulse clear -> phase=0, a_out=b_out=0, result_valid=0, op_count unchanged.
- Back-to-back operations: after a completed op, enter a new A and B -> result_valid stays 1 with the old result until the new opcode capture.
  - 256 completed ops -> op_count wraps to 0.
- Async reset in S_EXEC: hold ena=0 in S_EXEC, then assert rst_n -> outputs go to 0 without a clock edge, and op_count is not incremented.
